// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder: FSM state encoding
// and the width of the digit counter.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0 .. WIDTH/DIGIT-1; keep at least one bit.
    function automatic int calc_cnt_w(input int width, input int digit);
        int n;
        n = width / digit;
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple chain of full-adder cells; also exposes the
// carry into the top cell so the caller can form signed overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co       = w_c[DIGIT];
    assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder: adds WIDTH-bit operands plus carry-in DIGIT bits per
// clock, LSB digit first, with valid/ready handshakes and overflow flag.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_params
        $error("serial_adder_n: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE.
    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_count;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT-1:0]   w_s;
    logic               w_co;
    logic               w_c_msb_in;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_shift;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x        (r_a[DIGIT-1:0]),
        .y        (r_b[DIGIT-1:0]),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_c_msb_in)
    );

    assign w_last = (r_count == LAST);

    // Each new digit enters at the MSB end so the final digit lands on top.
    if (DIGIT == WIDTH) begin : g_sum_whole
        assign w_sum_shift = w_s;
    end else begin : g_sum_shift
        assign w_sum_shift = {w_s, r_sum[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_sum   <= w_sum_shift;
                    r_carry <= w_co;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_cout <= w_co;
                        r_ovf  <= w_co ^ w_c_msb_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: one DIGIT=1 and one DIGIT=4
// instance (WIDTH=8) compared against an arithmetic reference model.
module tb_serial_adder_n;

    logic       clk;
    logic       rst;

    logic       iv1, ir1, ov1, or1, cin1, cout1, ovf1;
    logic [7:0] a1, b1, sum1;
    logic       iv4, ir4, ov4, or4, cin4, cout4, ovf4;
    logic [7:0] a4, b4, sum4;

    int errors = 0;
    int checks = 0;

    // Expected {cout, ovf, sum} for random traffic.
    logic [9:0] exp_q[$];

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [9:0] model(input logic [7:0] aa, input logic [7:0] bb,
                                         input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, aa} + {1'b0, bb} + {8'd0, c};
        v = (aa[7] == bb[7]) && (t[7] != aa[7]);
        return {t[8], v, t[7:0]};
    endfunction

    // ---------------- observation helpers ----------------
    function automatic logic get_ov(input int w);
        return (w == 1) ? ov1 : ov4;
    endfunction

    function automatic logic get_ir(input int w);
        return (w == 1) ? ir1 : ir4;
    endfunction

    function automatic logic [9:0] get_res(input int w);
        return (w == 1) ? {cout1, ovf1, sum1} : {cout4, ovf4, sum4};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int w, input logic iv, input logic [7:0] aa,
                         input logic [7:0] bb, input logic c);
        if (w == 1) begin
            iv1 = iv; a1 = aa; b1 = bb; cin1 = c;
        end else begin
            iv4 = iv; a4 = aa; b4 = bb; cin4 = c;
        end
    endtask

    task automatic set_or(input int w, input logic v);
        if (w == 1) or1 = v;
        else        or4 = v;
    endtask

    task automatic start_op(input int w, input logic [7:0] aa, input logic [7:0] bb,
                            input logic c);
        @(negedge clk);
        drive(w, 1'b1, aa, bb, c);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    // Called #1 after the accept edge; counts edges until out_valid.
    task automatic wait_done(input int w, output int lat);
        lat = 0;
        while (get_ov(w) !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack(input int w);
        @(negedge clk);
        set_or(w, 1'b1);
        @(posedge clk);
        #1;
        set_or(w, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #3;
        for (int w = 1; w <= 4; w += 3) begin
            checks++;
            if (get_res(w) !== 10'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got=%h exp=000", w, get_res(w));
            end
            checks++;
            if (get_ov(w) !== 1'b0 || get_ir(w) !== 1'b1) begin
                errors++;
                $display("FAIL reset_handshake dut%0d got ov=%b ir=%b exp ov=0 ir=1",
                         w, get_ov(w), get_ir(w));
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'h80};
        logic [7:0] tb [3] = '{8'h27, 8'h01, 8'h80};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        int         tw [3] = '{1, 1, 4};
        logic [9:0] te [3] = '{{1'b0, 1'b1, 8'h81}, {1'b1, 1'b0, 8'h00}, {1'b1, 1'b1, 8'h01}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (get_ir(tw[i]) !== 1'b1) begin
                errors++;
                $display("FAIL directed_ready[%0d] got=%b exp=1", i, get_ir(tw[i]));
            end
            start_op(tw[i], ta[i], tb[i], tc[i]);
            checks++;
            if (get_ir(tw[i]) !== 1'b0) begin
                errors++;
                $display("FAIL directed_busy[%0d] in_ready got=%b exp=0", i, get_ir(tw[i]));
            end
            wait_done(tw[i], lat);
            checks++;
            if (lat !== 8 / tw[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, 8 / tw[i]);
            end
            checks++;
            if (get_res(tw[i]) !== te[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] got=%h exp=%h", i, get_res(tw[i]), te[i]);
            end
            ack(tw[i]);
        end
    endtask

    task automatic test_backpressure;
        logic [9:0] e;
        int lat;
        e = model(8'hC3, 8'h5E, 1'b1);
        start_op(1, 8'hC3, 8'h5E, 1'b1);
        wait_done(1, lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            checks++;
            if (ov1 !== 1'b1 || ir1 !== 1'b0 || get_res(1) !== e) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got ov=%b ir=%b res=%h exp ov=1 ir=0 res=%h",
                         k, ov1, ir1, get_res(1), e);
            end
        end
        @(negedge clk);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        or1 = 1'b1;
        @(posedge clk);
        #1;
        or1 = 1'b0;
        checks++;
        if (ov1 !== 1'b0 || ir1 !== 1'b1 || get_res(1) !== e) begin
            errors++;
            $display("FAIL backpressure_release got ov=%b ir=%b res=%h exp ov=0 ir=1 res=%h",
                     ov1, ir1, get_res(1), e);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        start_op(1, 8'h77, 8'h99, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (get_res(1) !== 10'd0 || ov1 !== 1'b0 || ir1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_run got res=%h ov=%b ir=%b exp res=000 ov=0 ir=1",
                     get_res(1), ov1, ir1);
        end
        @(negedge clk);
        rst = 1'b0;
        start_op(1, 8'h10, 8'h20, 1'b1);
        wait_done(1, lat);
        checks++;
        if (lat !== 8 || get_res(1) !== {1'b0, 1'b0, 8'h31}) begin
            errors++;
            $display("FAIL after_reset_op got lat=%0d res=%h exp lat=8 res=031", lat, get_res(1));
        end
        ack(1);
    endtask

    task automatic test_inputs_during_run;
        logic [7:0] xa, xb, ya, yb;
        logic       xc, yc;
        int lat;
        xa = 8'($urandom); xb = 8'($urandom); xc = 1'($urandom);
        ya = 8'($urandom); yb = 8'($urandom); yc = 1'($urandom);
        @(negedge clk);
        drive(1, 1'b1, xa, xb, xc);
        @(posedge clk);
        #1;
        lat = 0;
        while (ov1 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            drive(1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 8 || get_res(1) !== model(xa, xb, xc)) begin
            errors++;
            $display("FAIL busy_inputs got lat=%0d res=%h exp lat=8 res=%h",
                     lat, get_res(1), model(xa, xb, xc));
        end
        @(negedge clk);
        or1 = 1'b1;
        @(posedge clk);
        #1;
        or1 = 1'b0;
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0) begin
            errors++;
            $display("FAIL handshake_to_idle got ir=%b ov=%b exp ir=1 ov=0", ir1, ov1);
        end
        drive(1, 1'b1, ya, yb, yc);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_done(1, lat);
        checks++;
        if (lat !== 8 || get_res(1) !== model(ya, yb, yc)) begin
            errors++;
            $display("FAIL first_accept_after_done got lat=%0d res=%h exp lat=8 res=%h",
                     lat, get_res(1), model(ya, yb, yc));
        end
        ack(1);
    endtask

    task automatic test_random;
        logic [7:0] ra, rb;
        logic       rc;
        logic [9:0] e;
        int lat;
        for (int w = 1; w <= 4; w += 3) begin
            for (int n = 0; n < 12; n++) begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                if (n == 0) begin ra = 8'h7F; rb = 8'h00; rc = 1'b1; end
                if (n == 1) begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
                exp_q.push_back(model(ra, rb, rc));
                start_op(w, ra, rb, rc);
                wait_done(w, lat);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                e = exp_q.pop_front();
                checks++;
                if (lat !== 8 / w || get_res(w) !== e || get_ov(w) !== 1'b1) begin
                    errors++;
                    $display("FAIL random dut%0d a=%h b=%h cin=%b got lat=%0d res=%h exp lat=%0d res=%h",
                             w, ra, rb, rc, lat, get_res(w), 8 / w, e);
                end
                ack(w);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
        or1 = 1'b0;
        or4 = 1'b0;
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_run;
        test_inputs_during_run;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
